// File: rtl/mdu_pkg.sv
// Shared encodings, default latencies and result type for the multiply/divide unit.
package mdu_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] NONE  = 4'd0;
    localparam logic [OP_W-1:0] MULT  = 4'd1;
    localparam logic [OP_W-1:0] MULTU = 4'd2;
    localparam logic [OP_W-1:0] DIV   = 4'd3;
    localparam logic [OP_W-1:0] DIVU  = 4'd4;
    localparam logic [OP_W-1:0] MTHI  = 4'd5;
    localparam logic [OP_W-1:0] MTLO  = 4'd6;
    localparam logic [OP_W-1:0] MFHI  = 4'd7;
    localparam logic [OP_W-1:0] MFLO  = 4'd8;

    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;

    // wr is cleared for a divide by zero so the commit leaves HI/LO alone
    typedef struct packed {
        logic        wr;
        logic [31:0] hi;
        logic [31:0] lo;
    } md_res_t;

    function automatic logic is_start(input logic [OP_W-1:0] op);
        return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
    endfunction

    function automatic logic is_div(input logic [OP_W-1:0] op);
        return (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/mdu_if.sv
// Operand/result bundle between the register-file stage and the multiply/divide unit.
interface mdu_if;
    import mdu_pkg::*;

    logic [OP_W-1:0] md_op;
    logic [31:0]     A;
    logic [31:0]     B;
    logic            busy;
    logic [31:0]     HI;
    logic [31:0]     LO;
    logic [31:0]     md_out;

    modport master (output md_op, A, B, input busy, HI, LO, md_out);
    modport slave  (input md_op, A, B, output busy, HI, LO, md_out);

endinterface

// File: rtl/mdu_arith.sv
// Combinational product/quotient/remainder for MULT, MULTU, DIV and DIVU.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [OP_W-1:0] op,
    input  logic [31:0]     a,
    input  logic [31:0]     b,
    output md_res_t         res
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] sdiv;
    logic [31:0] udiv;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] uq;
    logic [31:0] ur;

    // Signed divide works on magnitudes so 0x80000000 / -1 needs no special case
    always_comb begin
        prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        prod_u = {32'd0, a} * {32'd0, b};
        abs_a  = a[31] ? -a : a;
        abs_b  = b[31] ? -b : b;
        sdiv   = (abs_b == 32'd0) ? 32'd1 : abs_b;
        udiv   = (b == 32'd0) ? 32'd1 : b;
        q_mag  = abs_a / sdiv;
        r_mag  = abs_a % sdiv;
        uq     = a / udiv;
        ur     = a % udiv;

        res = '0;
        case (op)
            MULT: begin
                res.wr = 1'b1;
                res.hi = prod_s[63:32];
                res.lo = prod_s[31:0];
            end
            MULTU: begin
                res.wr = 1'b1;
                res.hi = prod_u[63:32];
                res.lo = prod_u[31:0];
            end
            DIV: begin
                res.wr = (b != 32'd0);
                res.lo = (a[31] ^ b[31]) ? -q_mag : q_mag;
                res.hi = a[31] ? -r_mag : r_mag;
            end
            DIVU: begin
                res.wr = (b != 32'd0);
                res.lo = uq;
                res.hi = ur;
            end
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit: holds HI/LO, computes at acceptance and
// commits the pending result after a fixed latency while busy stalls the pipe.
module mdu
    import mdu_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic  clk,
    input  logic  reset,
    mdu_if.slave  bus
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             state_q, state_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic             pend_wr_q, pend_wr_d;
    md_res_t          res;

    mdu_arith u_arith (
        .op  (bus.md_op),
        .a   (bus.A),
        .b   (bus.B),
        .res (res)
    );

    // While running every md_op is ignored; only the countdown and commit act
    always_comb begin
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;

        if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE_CNT;
            if ((cnt_q == ONE_CNT) && pend_wr_q) begin
                hi_d = pend_hi_q;
                lo_d = pend_lo_q;
            end
        end else if (is_start(bus.md_op)) begin
            cnt_d     = is_div(bus.md_op) ? DIV_CNT : MUL_CNT;
            pend_hi_d = res.hi;
            pend_lo_d = res.lo;
            pend_wr_d = res.wr;
        end else if (bus.md_op == MTHI) begin
            hi_d = bus.A;
        end else if (bus.md_op == MTLO) begin
            lo_d = bus.A;
        end

        state_d = (cnt_d != '0) ? ST_RUN : ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q     <= '0;
            state_q   <= ST_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    always_comb begin
        case (bus.md_op)
            MFHI:    bus.md_out = hi_q;
            MFLO:    bus.md_out = lo_q;
            default: bus.md_out = '0;
        endcase
    end

    assign bus.busy = (state_q == ST_RUN);
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Bench for mdu: directed vector table, hand-written multi-cycle corner cases,
// then random operations checked against an arithmetic reference model.
module tb_mdu;
    import mdu_pkg::*;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic clk = 1'b0;
    logic reset;

    mdu_if bus ();

    mdu #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_pass = 0;
    int          n_total = 0;
    int          busy_cnt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    typedef struct {
        logic [OP_W-1:0] op;
        logic [31:0]     a;
        logic [31:0]     b;
        logic [31:0]     hi;
        logic [31:0]     lo;
    } vec_t;

    vec_t vecs[6];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.busy) busy_cnt++;
    endtask

    task automatic drive(input logic [OP_W-1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.md_op = op;
        bus.A     = a;
        bus.B     = b;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (bus.busy && guard < 100) begin
            tick();
            guard++;
        end
        if (bus.busy) check_output("idle_timeout", 32'd1, 32'd0);
    endtask

    // Architectural effect of one operation, straight from the arithmetic rules
    function automatic void model(input logic [OP_W-1:0] op, input logic [31:0] a, input logic [31:0] b);
        int                ia = a;
        int                ib = b;
        longint            sp, sq, sr;
        longint unsigned   ua = a;
        longint unsigned   ub = b;
        longint unsigned   up;
        case (op)
            MULT:  begin sp = longint'(ia) * longint'(ib); exp_hi = sp[63:32]; exp_lo = sp[31:0]; end
            MULTU: begin up = ua * ub; exp_hi = up[63:32]; exp_lo = up[31:0]; end
            DIV: if (b != 0) begin
                sq = longint'(ia) / longint'(ib);
                sr = longint'(ia) % longint'(ib);
                exp_lo = sq[31:0];
                exp_hi = sr[31:0];
            end
            DIVU: if (b != 0) begin
                up = ua / ub; exp_lo = up[31:0];
                up = ua % ub; exp_hi = up[31:0];
            end
            MTHI: exp_hi = a;
            MTLO: exp_lo = a;
            default: ;
        endcase
    endfunction

    task automatic apply_stimulus(input logic [OP_W-1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input string name);
        if (is_start(op)) begin
            busy_cnt = 0;
            drive(op, a, b);
            tick();
            drive(NONE, $urandom, $urandom);
            wait_idle();
            model(op, a, b);
            check_output({name, "_lat"}, busy_cnt, is_div(op) ? DIV_LAT : MUL_LAT);
        end else if (op == MFHI || op == MFLO) begin
            drive(op, a, b);
            #1;
            check_output({name, "_out"}, bus.md_out, (op == MFHI) ? exp_hi : exp_lo);
            tick();
            drive(NONE, 32'd0, 32'd0);
        end else begin
            drive(op, a, b);
            tick();
            drive(NONE, 32'd0, 32'd0);
            model(op, a, b);
        end
        check_output({name, "_hi"}, bus.HI, exp_hi);
        check_output({name, "_lo"}, bus.LO, exp_lo);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0] = '{MULT,  32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[1] = '{MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE};
        vecs[2] = '{DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{DIVU,  32'd7,        32'd2,        32'd1,        32'd3};
        vecs[4] = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
        vecs[5] = '{MULT,  32'd3,        32'd4,        32'd0,        32'd12};

        reset    = 1'b0;
        busy_cnt = 0;
        drive(NONE, 32'd0, 32'd0);
        tick();
        tick();
        check_output("rst_busy", {31'd0, bus.busy}, 32'd0);
        check_output("rst_hi", bus.HI, 32'd0);
        check_output("rst_lo", bus.LO, 32'd0);
        reset  = 1'b1;
        exp_hi = 32'd0;
        exp_lo = 32'd0;

        // MTHI then divide by zero: HI/LO untouched after the full divide latency
        apply_stimulus(MTHI, 32'h12345678, 32'd0, "mthi");
        check_output("mthi_const", bus.HI, 32'h12345678);
        apply_stimulus(DIVU, 32'd7, 32'd0, "divz");
        check_output("divz_hi_const", bus.HI, 32'h12345678);
        check_output("divz_lo_const", bus.LO, 32'd0);
        apply_stimulus(MFHI, 32'd0, 32'd0, "mfhi");

        drive(4'd12, 32'hCAFEF00D, 32'd1);
        #1;
        check_output("op12_out", bus.md_out, 32'd0);
        tick();
        check_output("op12_busy", {31'd0, bus.busy}, 32'd0);
        check_output("op12_hi", bus.HI, 32'h12345678);
        drive(NONE, 32'd0, 32'd0);

        for (int i = 0; i < 6; i++) begin
            apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
            check_output($sformatf("vec%0d_hi_tbl", i), bus.HI, vecs[i].hi);
            check_output($sformatf("vec%0d_lo_tbl", i), bus.LO, vecs[i].lo);
        end

        // Clear HI/LO, then MULT 3*4 with MTLO and DIVU injected while running
        reset = 1'b0;
        tick();
        reset = 1'b1;
        busy_cnt = 0;
        drive(MULT, 32'd3, 32'd4);
        tick();
        drive(NONE, 32'd0, 32'd0);
        tick();
        drive(MTLO, 32'h0000DEAD, 32'd0);
        tick();
        check_output("ign_mtlo_lo", bus.LO, 32'd0);
        drive(DIVU, 32'd7, 32'd2);
        tick();
        drive(NONE, 32'd0, 32'd0);
        wait_idle();
        check_output("ign_lat", busy_cnt, MUL_LAT);
        tick();
        check_output("ign_busy_after", {31'd0, bus.busy}, 32'd0);
        check_output("ign_hi", bus.HI, 32'd0);
        check_output("ign_lo", bus.LO, 32'd12);

        // Reset in the middle of MULTU 5*5 aborts the commit
        drive(MULTU, 32'd5, 32'd5);
        tick();
        drive(NONE, 32'd0, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_output("abort_busy", {31'd0, bus.busy}, 32'd0);
        check_output("abort_hi", bus.HI, 32'd0);
        check_output("abort_lo", bus.LO, 32'd0);
        repeat (8) tick();
        check_output("abort_lo_late", bus.LO, 32'd0);
        check_output("abort_busy_late", {31'd0, bus.busy}, 32'd0);
        exp_hi = 32'd0;
        exp_lo = 32'd0;

        // Back-to-back: new start in the first idle cycle, MFLO sees the old result
        apply_stimulus(MULT, 32'd6, 32'd7, "b2b_first");
        busy_cnt = 0;
        drive(MULTU, 32'h00010000, 32'h00010000);
        tick();
        check_output("b2b_accept", {31'd0, bus.busy}, 32'd1);
        drive(MFLO, 32'd0, 32'd0);
        #1;
        check_output("b2b_mflo", bus.md_out, 32'd42);
        wait_idle();
        drive(NONE, 32'd0, 32'd0);
        check_output("b2b_lat", busy_cnt, MUL_LAT);
        check_output("b2b_hi", bus.HI, 32'd1);
        check_output("b2b_lo", bus.LO, 32'd0);
        exp_hi = 32'd1;
        exp_lo = 32'd0;

        for (int i = 0; i < 40; i++) begin
            logic [OP_W-1:0] rop;
            logic [31:0]     ra, rb;
            case ($urandom_range(0, 7))
                0: rop = MULT;
                1: rop = MULTU;
                2: rop = DIV;
                3: rop = DIVU;
                4: rop = MTHI;
                5: rop = MTLO;
                6: rop = MFHI;
                default: rop = MFLO;
            endcase
            ra = $urandom;
            if ($urandom_range(0, 7) == 0) rb = 32'd0;
            else if ($urandom_range(0, 1) == 0) rb = $urandom;
            else rb = $urandom_range(1, 20);
            if ($urandom_range(0, 1) == 0) rb = -rb;
            apply_stimulus(rop, ra, rb, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
